// File: rtl/alu_issue.sv
// alu_issue: accepts decoded instructions, drives the ALU's one-hot control and
// operands for the op's latency, then hands the result to writeback. It also
// owns the architectural {GT, ET} flag register that CMP updates.
//
// alu_sig bit order (isAdd .. isMov):
//   0 add, 1 sub, 2 cmp, 3 mul, 4 div, 5 mod, 6 lsl, 7 lsr, 8 asr,
//   9 or, 10 and, 11 not, 12 mov
// Flag vectors are {GT, ET} with GT in bit 1.
module alu_issue #(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [12:0] alu_sig,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic [1:0]  alu_flag,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [1:0]  flags_q,
  output logic        illegal
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [4:0] OP_MOD = 5'd4;
  localparam logic [4:0] OP_CMP = 5'd5;
  localparam logic [4:0] OP_ASR = 5'd12;
  localparam logic [4:0] OP_NOP = 5'd13;

  state_t      state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [3:0]  rd_q, rd_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  flags_d;
  logic        illegal_q, illegal_d;

  // Instruction fields
  logic [4:0]  opc;
  logic        imm_f;
  logic [1:0]  modif;
  logic [15:0] imm16;
  logic        unused_inst_bits;

  assign opc   = inst[31:27];
  assign imm_f = inst[26];
  assign modif = inst[17:16];
  assign imm16 = inst[15:0];
  assign unused_inst_bits = ^inst[21:18];

  logic [31:0] imm_ext;
  logic [31:0] b_sel;
  logic [4:0]  lat_m1;
  logic [12:0] sig_dec;

  // Immediate extension and operand-B select; modifier 11 behaves like 00
  always_comb begin
    imm_ext = {{16{imm16[15]}}, imm16};
    case (modif)
      2'b01:   imm_ext = {16'h0000, imm16};
      2'b10:   imm_ext = {imm16, 16'h0000};
      default: imm_ext = {{16{imm16[15]}}, imm16};
    endcase
    b_sel = imm_f ? imm_ext : op2;
  end

  // Latency counter preload (L-1) for the incoming opcode
  always_comb begin
    lat_m1 = 5'd0;
    if (opc == OP_MUL)
      lat_m1 = 5'(MUL_LAT - 1);
    else if (opc == OP_DIV || opc == OP_MOD)
      lat_m1 = 5'(DIV_LAT - 1);
  end

  // One-hot ALU control decode of the latched opcode
  always_comb begin
    sig_dec = '0;
    case (op_q)
      5'd0:    sig_dec[0]  = 1'b1;
      5'd1:    sig_dec[1]  = 1'b1;
      5'd2:    sig_dec[3]  = 1'b1;
      5'd3:    sig_dec[4]  = 1'b1;
      5'd4:    sig_dec[5]  = 1'b1;
      5'd5:    sig_dec[2]  = 1'b1;
      5'd6:    sig_dec[10] = 1'b1;
      5'd7:    sig_dec[9]  = 1'b1;
      5'd8:    sig_dec[11] = 1'b1;
      5'd9:    sig_dec[12] = 1'b1;
      5'd10:   sig_dec[6]  = 1'b1;
      5'd11:   sig_dec[7]  = 1'b1;
      5'd12:   sig_dec[8]  = 1'b1;
      default: sig_dec     = '0;
    endcase
  end

  // Next-state logic for the IDLE/EXEC/WB sequencer and its datapath
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    flags_d   = flags_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = opc;
          rd_d  = inst[25:22];
          a_d   = op1;
          b_d   = b_sel;
          cnt_d = lat_m1;
          if (opc <= OP_ASR)
            state_d = S_EXEC;
          else if (opc != OP_NOP)
            illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (cnt_q == 5'd0) begin
          if (op_q == OP_CMP) begin
            flags_d = alu_flag;
            state_d = S_IDLE;
          end else begin
            data_d  = alu_result;
            state_d = S_WB;
          end
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_WB: begin
        if (wb_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with asynchronous reset that drops any in-flight op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= 5'd0;
      rd_q      <= 4'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      cnt_q     <= 5'd0;
      data_q    <= 32'd0;
      flags_q   <= 2'b00;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign wb_valid = (state_q == S_WB);
  assign alu_sig  = (state_q == S_EXEC) ? sig_dec : 13'd0;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign wb_rd    = rd_q;
  assign wb_data  = data_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue with a small reference ALU on the ALU side.
module tb_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [12:0] alu_sig;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic [1:0]  alu_flag;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  flags_q;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  alu_issue #(.MUL_LAT(2), .DIV_LAT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inst       (inst),
    .op1        (op1),
    .op2        (op2),
    .alu_sig    (alu_sig),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_flag   (alu_flag),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .flags_q    (flags_q),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: bit order add,sub,cmp,mul,div,mod,lsl,lsr,asr,or,and,not,mov
  always_comb begin
    alu_result = 32'd0;
    if (alu_sig[0])  alu_result = alu_a + alu_b;
    if (alu_sig[1])  alu_result = alu_a - alu_b;
    if (alu_sig[3])  alu_result = alu_a * alu_b;
    if (alu_sig[4])  alu_result = (alu_b != 0) ? alu_a / alu_b : 32'd0;
    if (alu_sig[5])  alu_result = (alu_b != 0) ? alu_a % alu_b : 32'd0;
    if (alu_sig[6])  alu_result = alu_a << alu_b[4:0];
    if (alu_sig[7])  alu_result = alu_a >> alu_b[4:0];
    if (alu_sig[8])  alu_result = 32'($signed(alu_a) >>> alu_b[4:0]);
    if (alu_sig[9])  alu_result = alu_a | alu_b;
    if (alu_sig[10]) alu_result = alu_a & alu_b;
    if (alu_sig[11]) alu_result = ~alu_b;
    if (alu_sig[12]) alu_result = alu_b;
    alu_flag = {($signed(alu_a) > $signed(alu_b)), (alu_a == alu_b)};
  end

  function automatic int opc_bit(input logic [4:0] opc);
    case (opc)
      5'd0: return 0;   5'd1: return 1;   5'd2: return 3;   5'd3: return 4;
      5'd4: return 5;   5'd5: return 2;   5'd6: return 10;  5'd7: return 9;
      5'd8: return 11;  5'd9: return 12;  5'd10: return 6;  5'd11: return 7;
      5'd12: return 8;  default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction; returns in the cycle after the accepting edge
  task automatic issue(input logic [4:0] opc, input logic i, input logic [1:0] modif,
                       input logic [15:0] imm, input logic [3:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    inst     = {opc, i, rd, 4'b0000, modif, imm};
    op1      = a;
    op2      = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_alu_sig"},  32'(alu_sig),  32'd0);
    check({tag, "_alu_a"},    alu_a,         32'd0);
    check({tag, "_alu_b"},    alu_b,         32'd0);
    check({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    check({tag, "_wb_rd"},    32'(wb_rd),    32'd0);
    check({tag, "_wb_data"},  wb_data,       32'd0);
    check({tag, "_flags"},    32'(flags_q),  32'd0);
    check({tag, "_illegal"},  32'(illegal),  32'd0);
  endtask

  // Full writeback op: control held for lat cycles, then WB with wb_ready=1
  task automatic run_op(input string tag, input logic [4:0] opc, input logic i,
                        input logic [1:0] modif, input logic [15:0] imm,
                        input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] exp_b, input logic [31:0] exp_data);
    logic [12:0] exp_sig;
    exp_sig = 13'd1 << opc_bit(opc);
    issue(opc, i, modif, imm, rd, a, b);
    for (int k = 0; k < lat; k++) begin
      check({tag, "_sig"},      32'(alu_sig),  32'(exp_sig));
      check({tag, "_a"},        alu_a,         a);
      check({tag, "_b"},        alu_b,         exp_b);
      check({tag, "_wbv_exec"}, 32'(wb_valid), 32'd0);
      check({tag, "_rdy_exec"}, 32'(in_ready), 32'd0);
      tick();
    end
    check({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
    check({tag, "_wb_rd"},    32'(wb_rd),    32'(rd));
    check({tag, "_wb_data"},  wb_data,       exp_data);
    check({tag, "_sig_wb"},   32'(alu_sig),  32'd0);
    tick();
    check({tag, "_rdy_after"}, 32'(in_ready), 32'd1);
    check({tag, "_wbv_after"}, 32'(wb_valid), 32'd0);
  endtask

  initial begin
    logic seen_wb;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    wb_ready = 1'b1;
    inst     = 32'd0;
    op1      = 32'd0;
    op2      = 32'd0;
    tick();
    tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // ADD register operands, MUL/DIV/MOD latencies, misc ops
    run_op("add",  5'd0,  1'b0, 2'b00, 16'h0, 4'd3, 32'd5,   32'd7, 1,  32'd7, 32'd12);
    run_op("mul",  5'd2,  1'b0, 2'b00, 16'h0, 4'd1, 32'd6,   32'd7, 2,  32'd7, 32'd42);
    run_op("div",  5'd3,  1'b0, 2'b00, 16'h0, 4'd5, 32'd100, 32'd7, 16, 32'd7, 32'd14);
    run_op("mod",  5'd4,  1'b0, 2'b00, 16'h0, 4'd6, 32'd100, 32'd7, 16, 32'd7, 32'd2);
    run_op("sub",  5'd1,  1'b0, 2'b00, 16'h0, 4'd2, 32'd10,  32'd3, 1,  32'd3, 32'd7);
    run_op("lsl",  5'd10, 1'b0, 2'b00, 16'h0, 4'd8, 32'd3,   32'd4, 1,  32'd4, 32'd48);
    run_op("and",  5'd6,  1'b0, 2'b00, 16'h0, 4'd9, 32'hF0F0, 32'hFF00, 1, 32'hFF00, 32'hF000);

    // Immediate extension through MOV
    run_op("mov_m00", 5'd9, 1'b1, 2'b00, 16'hFFFF, 4'd4, 32'd1, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mov_m01", 5'd9, 1'b1, 2'b01, 16'hFFFF, 4'd4, 32'd1, 32'd0, 1, 32'h0000_FFFF, 32'h0000_FFFF);
    run_op("mov_m10", 5'd9, 1'b1, 2'b10, 16'h1234, 4'd4, 32'd1, 32'd0, 1, 32'h1234_0000, 32'h1234_0000);
    run_op("mov_m11", 5'd9, 1'b1, 2'b11, 16'h8000, 4'd4, 32'd1, 32'd0, 1, 32'hFFFF_8000, 32'hFFFF_8000);
    run_op("add_imm", 5'd0, 1'b1, 2'b01, 16'h0010, 4'd10, 32'd5, 32'd99, 1, 32'h10, 32'h15);

    // CMP: 9 vs 4 -> GT
    issue(5'd5, 1'b0, 2'b00, 16'h0, 4'd2, 32'd9, 32'd4);
    check("cmp_sig", 32'(alu_sig), 32'(13'd1 << 2));
    check("cmp_rdy_exec", 32'(in_ready), 32'd0);
    tick();
    check("cmp_rdy_back", 32'(in_ready), 32'd1);
    check("cmp_no_wb", 32'(wb_valid), 32'd0);
    check("cmp_flags_gt", 32'(flags_q), 32'b10);
    run_op("add_after_cmp", 5'd0, 1'b0, 2'b00, 16'h0, 4'd3, 32'd1, 32'd2, 1, 32'd2, 32'd3);
    check("flags_kept_add", 32'(flags_q), 32'b10);

    // CMP equal -> ET, then CMP less -> none, then GT again for the reset test
    issue(5'd5, 1'b0, 2'b00, 16'h0, 4'd2, 32'd7, 32'd7);
    tick();
    check("cmp_flags_et", 32'(flags_q), 32'b01);
    issue(5'd5, 1'b0, 2'b00, 16'h0, 4'd2, 32'd3, 32'd9);
    tick();
    check("cmp_flags_lt", 32'(flags_q), 32'b00);
    issue(5'd5, 1'b0, 2'b00, 16'h0, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    tick();
    check("cmp_flags_neg_gt", 32'(flags_q), 32'b10);

    // Writeback backpressure with a competing instruction held on the input
    wb_ready = 1'b0;
    issue(5'd0, 1'b0, 2'b00, 16'h0, 4'd7, 32'd2, 32'd3);
    inst     = {5'd0, 1'b0, 4'd9, 22'd0};
    op1      = 32'd1;
    op2      = 32'd1;
    in_valid = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_wb_valid", 32'(wb_valid), 32'd1);
      check("bp_wb_data",  wb_data,       32'd5);
      check("bp_wb_rd",    32'(wb_rd),    32'd7);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_flags",    32'(flags_q),  32'b10);
      tick();
    end
    wb_ready = 1'b1;
    check("bp_last_wb_data", wb_data, 32'd5);
    tick();
    check("bp_released_idle", 32'(in_ready), 32'd1);
    check("bp_released_wbv", 32'(wb_valid), 32'd0);
    check("bp_not_taken_in_wb", 32'(alu_sig), 32'd0);
    tick();
    in_valid = 1'b0;
    check("bp_pending_sig", 32'(alu_sig), 32'd1);
    tick();
    check("bp_pending_wbv", 32'(wb_valid), 32'd1);
    check("bp_pending_rd",  32'(wb_rd),    32'd9);
    check("bp_pending_data", wb_data,      32'd2);
    tick();

    // Illegal opcode (beq) and NOP
    issue(5'b10000, 1'b0, 2'b00, 16'h0, 4'd1, 32'd0, 32'd0);
    check("ill_pulse",   32'(illegal),  32'd1);
    check("ill_rdy",     32'(in_ready), 32'd1);
    check("ill_no_exec", 32'(alu_sig),  32'd0);
    tick();
    check("ill_pulse_end", 32'(illegal), 32'd0);
    check("ill_no_wb",   32'(wb_valid), 32'd0);
    check("ill_flags",   32'(flags_q),  32'b10);
    issue(5'd13, 1'b0, 2'b00, 16'h0, 4'd1, 32'd0, 32'd0);
    check("nop_rdy",     32'(in_ready), 32'd1);
    check("nop_no_exec", 32'(alu_sig),  32'd0);
    check("nop_no_ill",  32'(illegal),  32'd0);
    tick();
    check("nop_no_wb",   32'(wb_valid), 32'd0);

    // Asynchronous reset at EXEC cycle 8 of a DIV
    issue(5'd3, 1'b0, 2'b00, 16'h0, 4'd4, 32'd100, 32'd7);
    repeat (7) tick();
    check("rst_div_sig", 32'(alu_sig), 32'(13'd1 << 4));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid_div");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen_wb = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      seen_wb = seen_wb | wb_valid;
    end
    check("rst_no_wb", 32'(seen_wb), 32'd0);
    check("rst_idle_rdy", 32'(in_ready), 32'd1);
    check("rst_flags", 32'(flags_q), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
